// File: rtl/param_code_lock.sv
// Parametrised keypad code lock. Supports user and admin codes, atomic code change,
// lockout after repeated failures, and an inter-digit entry timeout.
module param_code_lock #(
    parameter int DIGITS      = 4,
    parameter int CODE_W      = 4,
    parameter int MAX_TRIES   = 5,
    parameter int LOCKOUT_CYC = 16,
    parameter int ENTRY_TO    = 64,
    parameter logic [DIGITS*CODE_W-1:0] ADMIN_CODE = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                cmd,
    input  logic                      cmd_valid,
    input  logic [CODE_W-1:0]         code,
    input  logic                      code_valid,
    output logic                      unlock,
    output logic                      err,
    output logic                      alert,
    output logic                      busy,
    output logic [2:0]                state_out,
    output logic [$clog2(DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int ENT_W = $clog2(ENTRY_TO + 1);
    localparam int LCK_W = $clog2(LOCKOUT_CYC + 1);

    localparam logic [1:0] CMD_SET      = 2'd0;
    localparam logic [1:0] CMD_VALIDATE = 2'd1;
    localparam logic [1:0] CMD_RELOCK   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET     = 3'd1,
        ST_VAL     = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;
    logic                       alert_q, alert_d;
    logic                       mismatch_q, mismatch_d;
    logic [IDX_W-1:0]           digit_idx_q, digit_idx_d;
    logic [TRY_W-1:0]           tries_q, tries_d;
    logic [ENT_W-1:0]           entry_timer_q, entry_timer_d;
    logic [LCK_W-1:0]           lock_timer_q, lock_timer_d;
    logic [DIGITS*CODE_W-1:0]   user_code_q, user_code_d;
    logic [DIGITS*CODE_W-1:0]   shadow_q, shadow_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            alert_q       <= 1'b0;
            mismatch_q    <= 1'b0;
            digit_idx_q   <= '0;
            tries_q       <= '0;
            entry_timer_q <= '0;
            lock_timer_q  <= '0;
            user_code_q   <= '0;
            shadow_q      <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            alert_q       <= alert_d;
            mismatch_q    <= mismatch_d;
            digit_idx_q   <= digit_idx_d;
            tries_q       <= tries_d;
            entry_timer_q <= entry_timer_d;
            lock_timer_q  <= lock_timer_d;
            user_code_q   <= user_code_d;
            shadow_q      <= shadow_d;
        end
    end

    logic [CODE_W-1:0] digit_exp;
    logic              is_last, abort_cmd, timeout, miss, do_fail;
    logic [TRY_W-1:0]  tries_inc;

    always_comb begin
        state_d       = state_q;
        alert_d       = alert_q;
        mismatch_d    = mismatch_q;
        digit_idx_d   = digit_idx_q;
        tries_d       = tries_q;
        user_code_d   = user_code_q;
        shadow_d      = shadow_q;
        err_d         = 1'b0;
        entry_timer_d = '0;
        lock_timer_d  = '0;
        do_fail       = 1'b0;
        miss          = mismatch_q;

        digit_exp = alert_q ? ADMIN_CODE[int'(digit_idx_q)*CODE_W +: CODE_W]
                            : user_code_q[int'(digit_idx_q)*CODE_W +: CODE_W];
        is_last   = (digit_idx_q == IDX_W'(DIGITS - 1));
        abort_cmd = cmd_valid && (cmd == CMD_RELOCK);
        timeout   = (entry_timer_q == ENT_W'(ENTRY_TO - 1));
        tries_inc = (tries_q == TRY_W'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd == CMD_VALIDATE) begin
                    state_d     = ST_VAL;
                    digit_idx_d = '0;
                    mismatch_d  = 1'b0;
                end
            end
            ST_OPEN: begin
                if (cmd_valid && cmd == CMD_RELOCK) begin
                    state_d = ST_IDLE;
                end else if (cmd_valid && cmd == CMD_SET) begin
                    state_d     = ST_SET;
                    digit_idx_d = '0;
                    shadow_d    = '0;
                end
            end
            ST_SET: begin
                if (abort_cmd) begin
                    state_d     = ST_OPEN;
                    digit_idx_d = '0;
                    shadow_d    = '0;
                end else if (code_valid) begin
                    shadow_d[int'(digit_idx_q)*CODE_W +: CODE_W] = code;
                    if (is_last) begin
                        user_code_d = shadow_d;
                        state_d     = ST_OPEN;
                        digit_idx_d = '0;
                    end else begin
                        digit_idx_d = digit_idx_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d     = ST_OPEN;
                    digit_idx_d = '0;
                    shadow_d    = '0;
                end else begin
                    entry_timer_d = entry_timer_q + 1'b1;
                end
            end
            ST_VAL: begin
                // Mismatches are only acted on at the final digit so the position stays hidden
                if (abort_cmd) begin
                    state_d     = ST_IDLE;
                    digit_idx_d = '0;
                    mismatch_d  = 1'b0;
                end else if (code_valid) begin
                    miss = mismatch_q || (code != digit_exp);
                    if (is_last) begin
                        digit_idx_d = '0;
                        mismatch_d  = 1'b0;
                        if (!miss) begin
                            state_d = ST_OPEN;
                            tries_d = '0;
                            if (alert_q) begin
                                alert_d     = 1'b0;
                                user_code_d = '0;
                            end
                        end else begin
                            do_fail = 1'b1;
                        end
                    end else begin
                        digit_idx_d = digit_idx_q + 1'b1;
                        mismatch_d  = miss;
                    end
                end else if (timeout) begin
                    do_fail = 1'b1;
                end else begin
                    entry_timer_d = entry_timer_q + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (lock_timer_q == LCK_W'(LOCKOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    lock_timer_d = lock_timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_fail) begin
            err_d       = 1'b1;
            digit_idx_d = '0;
            mismatch_d  = 1'b0;
            if (alert_q) begin
                state_d = ST_LOCKOUT;
            end else begin
                tries_d = tries_inc;
                if (tries_inc == TRY_W'(MAX_TRIES)) begin
                    alert_d = 1'b1;
                    state_d = ST_LOCKOUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end

        busy_d = (state_d == ST_SET) || (state_d == ST_VAL) || (state_d == ST_LOCKOUT);
    end

    // The door stays unlocked while a new code is being entered from OPEN
    always_comb begin
        unlock    = (state_q == ST_OPEN) || (state_q == ST_SET);
        err       = err_q;
        alert     = alert_q;
        busy      = busy_q;
        state_out = state_q;
        digit_idx = digit_idx_q;
    end

endmodule

// File: tb/tb_param_code_lock.sv
// Scoreboard bench for param_code_lock: entry outcomes are queued by the stimulus
// and checked by a monitor when the DUT reports an err pulse or an unlock edge.
module tb_param_code_lock;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cmd = 2'd0;
    logic       cmd_valid = 1'b0;
    logic [3:0] code = 4'd0;
    logic       code_valid = 1'b0;
    logic       unlock, err, alert, busy;
    logic [2:0] state_out;
    logic [1:0] digit_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit         is_err;
        logic [2:0] st;
        logic       al;
    } exp_t;

    exp_t exp_q[$];
    logic unlock_prev = 1'b0;
    logic err_prev    = 1'b0;

    param_code_lock dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .code       (code),
        .code_valid (code_valid),
        .unlock     (unlock),
        .err        (err),
        .alert      (alert),
        .busy       (busy),
        .state_out  (state_out),
        .digit_idx  (digit_idx)
    );

    always #5 clk = ~clk;

    // Monitor: every err pulse or unlock rising edge must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            unlock_prev = 1'b0;
            err_prev    = 1'b0;
        end else begin
            if (err || (unlock && !unlock_prev)) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL unexpected_event: got err=%0b unlock=%0b state=%0d, required no event",
                             err, unlock, state_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err != err || e.st != state_out || e.al != alert || (err && err_prev)) begin
                        tests_failed++;
                        $display("[TB] FAIL event: got err=%0b state=%0d alert=%0b prev_err=%0b, required err=%0b state=%0d alert=%0b prev_err=0",
                                 err, state_out, alert, err_prev, e.is_err, e.st, e.al);
                    end
                end
            end
            unlock_prev = unlock;
            err_prev    = err;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic cv, input logic [1:0] c, input logic dv, input logic [3:0] d);
        cmd_valid  = cv;
        cmd        = c;
        code_valid = dv;
        code       = d;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        code_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        applyStimulus(1'b1, c, 1'b0, 4'd0);
    endtask

    task automatic enter_digits(input logic [15:0] digits, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 1'b1, digits[i*4 +: 4]);
    endtask

    task automatic expect_event(input bit is_err, input logic [2:0] st, input logic al);
        exp_t e;
        e.is_err = is_err;
        e.st     = st;
        e.al     = al;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (state_out != 3'd0 && n < bound) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 4'd0);
            n++;
        end
        checkOutput(name, 32'(state_out), 32'd0);
    endtask

    initial begin
        int cycles;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst_unlock", 32'(unlock), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_alert", 32'(alert), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_state", 32'(state_out), 32'd0);
        checkOutput("rst_idx", 32'(digit_idx), 32'd0);

        // SET in IDLE is ignored
        send_cmd(2'd0);
        checkOutput("idle_set_ignored", 32'(state_out), 32'd0);

        // Default code 0000 opens
        send_cmd(2'd1);
        checkOutput("val_state", 32'(state_out), 32'd2);
        checkOutput("val_busy", 32'(busy), 32'd1);
        expect_event(1'b0, 3'd3, 1'b0);
        enter_digits(16'h0000, 2);
        checkOutput("val_idx2", 32'(digit_idx), 32'd2);
        enter_digits(16'h0000, 2);
        checkOutput("open_unlock", 32'(unlock), 32'd1);
        checkOutput("open_state", 32'(state_out), 32'd3);
        checkOutput("open_busy", 32'(busy), 32'd0);

        // VALIDATE in OPEN is ignored; then change code to 3,7,1,9
        send_cmd(2'd1);
        checkOutput("open_val_ignored", 32'(state_out), 32'd3);
        send_cmd(2'd0);
        checkOutput("set_state", 32'(state_out), 32'd1);
        enter_digits(16'h9173, 4);
        checkOutput("set_commit_state", 32'(state_out), 32'd3);
        checkOutput("set_commit_unlock", 32'(unlock), 32'd1);
        send_cmd(2'd2);
        checkOutput("relock_unlock", 32'(unlock), 32'd0);
        checkOutput("relock_state", 32'(state_out), 32'd0);

        // Wrong then right
        expect_event(1'b1, 3'd0, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'h8173, 4);
        checkOutput("wrong_unlock", 32'(unlock), 32'd0);
        expect_event(1'b0, 3'd3, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'h9173, 4);
        checkOutput("right_unlock", 32'(unlock), 32'd1);
        send_cmd(2'd2);

        // Five failures raise alert and lock out for 16 cycles
        for (int k = 0; k < 5; k++) begin
            expect_event(1'b1, (k == 4) ? 3'd4 : 3'd0, (k == 4) ? 1'b1 : 1'b0);
            send_cmd(2'd1);
            enter_digits(16'h1111, 4);
        end
        checkOutput("lock_alert", 32'(alert), 32'd1);
        checkOutput("lock_busy", 32'(busy), 32'd1);
        cycles = 0;
        while (state_out == 3'd4 && cycles < 100) begin
            cycles++;
            applyStimulus(1'b1, 2'd1, 1'b1, 4'd0);
        end
        checkOutput("lock_cycles", 32'(cycles), 32'd16);
        checkOutput("lock_end_state", 32'(state_out), 32'd0);
        checkOutput("lock_end_busy", 32'(busy), 32'd0);
        checkOutput("lock_end_alert", 32'(alert), 32'd1);

        // Admin failure relocks; admin success clears alert and user code
        expect_event(1'b1, 3'd4, 1'b1);
        send_cmd(2'd1);
        enter_digits(16'hEFFF, 4);
        wait_idle("admin_fail_lockout", 100);
        checkOutput("admin_fail_alert", 32'(alert), 32'd1);
        expect_event(1'b0, 3'd3, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'hFFFF, 4);
        checkOutput("admin_open_alert", 32'(alert), 32'd0);
        send_cmd(2'd2);
        expect_event(1'b0, 3'd3, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'h0000, 4);
        checkOutput("code_zeroed_open", 32'(unlock), 32'd1);
        send_cmd(2'd2);

        // Abort with simultaneous digit: no err, tries unchanged
        send_cmd(2'd1);
        enter_digits(16'h0021, 2);
        applyStimulus(1'b1, 2'd2, 1'b1, 4'd5);
        checkOutput("abort_state", 32'(state_out), 32'd0);
        checkOutput("abort_idx", 32'(digit_idx), 32'd0);

        // Entry timeout counts as a failure after 64 idle cycles
        expect_event(1'b1, 3'd0, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'h0021, 2);
        cycles = 0;
        while (state_out == 3'd2 && cycles < 200) begin
            cycles++;
            applyStimulus(1'b0, 2'd0, 1'b0, 4'd0);
        end
        checkOutput("timeout_cycles", 32'(cycles), 32'd64);

        // tries is now 1, so exactly four more failures must raise alert
        for (int k = 0; k < 4; k++) begin
            expect_event(1'b1, (k == 3) ? 3'd4 : 3'd0, (k == 3) ? 1'b1 : 1'b0);
            send_cmd(2'd1);
            enter_digits(16'h2222, 4);
        end
        wait_idle("lockout2_end", 100);
        expect_event(1'b0, 3'd3, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'hFFFF, 4);
        send_cmd(2'd2);

        // Reset in the middle of SET
        expect_event(1'b0, 3'd3, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'h0000, 4);
        send_cmd(2'd0);
        enter_digits(16'h0044, 2);
        rst = 1'b1;
        #1;
        checkOutput("midset_rst_state", 32'(state_out), 32'd0);
        checkOutput("midset_rst_unlock", 32'(unlock), 32'd0);
        checkOutput("midset_rst_busy", 32'(busy), 32'd0);
        checkOutput("midset_rst_idx", 32'(digit_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_event(1'b0, 3'd3, 1'b0);
        send_cmd(2'd1);
        enter_digits(16'h0000, 4);
        checkOutput("after_rst_open", 32'(unlock), 32'd1);

        repeat (3) applyStimulus(1'b0, 2'd0, 1'b0, 4'd0);
        checkOutput("events_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_code_lock.md
Name: param_code_lock

Overview:
- Parametrised successor of the team's 4-digit keypad lock.
- Generalises digit count, digit width, retry limit and admin code.
- Adds per-digit entry strobes, explicit abort/relock commands, timed lockout after repeated failures, and an inter-digit entry timeout.
- Sits between the debounced keypad front end and the door actuator / status display logic.

Parameters:
- DIGITS, 4, number of digits per code (2..8).
- CODE_W, 4, bits per digit.
- MAX_TRIES, 5, consecutive user failures that raise alert.
- LOCKOUT_CYC, 16, cycles all input is ignored after alert is raised or an admin failure.
- ENTRY_TO, 64, max idle cycles between digits inside an entry before it is rejected.
- ADMIN_CODE, all ones (DIGITS*CODE_W bits), admin code; digit 0 is in the LSBs.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd  in  2  0=SET, 1=VALIDATE, 2=RELOCK/ABORT, 3=reserved (ignored)
- cmd_valid  in  1  command strobe, one cycle
- code  in  CODE_W  digit value
- code_valid  in  1  digit strobe, one cycle
- unlock  out  1  level, high while in OPEN
- err  out  1  one-cycle pulse on a rejected entry
- alert  out  1  level, admin mode active
- busy  out  1  high in SET, VAL and LOCKOUT
- state_out  out  3  encoded FSM state for display
- digit_idx  out  $clog2(DIGITS)  index of the next expected digit

Behaviour:
- Reset (async):
  - FSM goes to IDLE.
  - User code is cleared to 0 on all digits.
  - tries=0; unlock=0, err=0, alert=0, busy=0, digit_idx=0; timers cleared.
- State encoding: IDLE=0, SET=1, VAL=2, OPEN=3, LOCKOUT=4.
- IDLE:
  - cmd_valid with VALIDATE goes to VAL, digit_idx=0.
  - SET and RELOCK are ignored.
  - code_valid is ignored.
- VAL:
  - Each code_valid compares code with expected digit[digit_idx]. Expected is the user code when alert=0, ADMIN_CODE when alert=1.
  - A mismatch sets a sticky internal flag. Entry always continues to the last digit, so failure position is never revealed.
  - digit_idx increments per accepted digit.
  - Match on the final digit: next cycle enters OPEN, unlock=1, tries=0. If alert was set, alert clears and the user code resets to all zeros.
  - Mismatch on the final digit, user mode:
    - err pulses 1 cycle and tries increments (saturating).
    - If tries reaches MAX_TRIES: alert=1, go to LOCKOUT.
    - Otherwise go to IDLE.
  - Mismatch on the final digit, admin mode: err pulses 1 cycle, go to LOCKOUT; alert stays 1.
- SET:
  - Accepted only from OPEN.
  - Digits are captured into a shadow register, not the live code.
  - On the final digit the shadow is committed atomically; state returns to OPEN and unlock stays 1.
- OPEN:
  - RELOCK goes to IDLE; unlock drops the following cycle.
  - SET goes to SET; VALIDATE is ignored.
- ABORT (cmd=2) in SET or VAL:
  - Partial entry is discarded, shadow discarded, go to IDLE (SET aborted returns to OPEN).
  - No err, tries unchanged.
- Entry timeout:
  - In SET or VAL, a counter reloads on every code_valid.
  - After ENTRY_TO cycles with no digit, VAL is treated as a failed final digit (err, tries rules apply).
  - SET timing out returns to OPEN with the shadow discarded, no err.
- LOCKOUT:
  - Counts LOCKOUT_CYC cycles; all cmd_valid and code_valid are ignored.
  - Then goes to IDLE; alert remains 1.
- Simultaneous cmd_valid and code_valid:
  - In SET/VAL, an ABORT wins and the digit is dropped.
  - Other cmds are ignored while an entry is in progress.
- err is never high in two consecutive cycles.
- busy is registered alongside the state.
- Reset mid-entry or mid-lockout is immediate: all state is lost except nothing; the user code returns to 0.

Test Plan:
- After reset, VALIDATE with digits 0,0,0,0 -> OPEN 1 cycle after the 4th strobe, unlock=1, state_out=3, tries=0.
- From OPEN: SET with 3,7,1,9, then RELOCK, then VALIDATE 3,7,1,8 -> err pulses once, tries=1, state IDLE, unlock=0. Then VALIDATE 3,7,1,9 -> OPEN.
- Five wrong VALIDATE entries -> after the 5th: alert=1, busy=1 for exactly LOCKOUT_CYC=16 cycles; strobes during that window have no effect. Then VALIDATE F,F,F,F -> OPEN, alert=0, user code = 0,0,0,0.
- In alert mode, VALIDATE F,F,F,E -> err, LOCKOUT again, alert stays 1.
- In VAL after 2 digits: ABORT together with code_valid -> IDLE, no err, tries unchanged. Then 2 digits and 64 idle cycles -> err, tries+1.
- Assert rst mid-SET after 2 digits -> immediate IDLE, all outputs 0; code 0,0,0,0 still opens (shadow never committed).
